// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu - registered, handshaked ALU with iterative multiply and divide.
//
// Operands are taken when in_valid_i && in_ready_o (state IDLE). Single-cycle
// operations present their result one cycle later. MUL/MLL and DIV with a
// non-zero divisor step once per cycle for WIDTH cycles in BUSY, giving
// WIDTH+1 cycles of latency. The result is held in DONE until out_ready_i.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o    operand handshake (in_ready_o only in IDLE)
//   a_i, b_i             operands (b_i[clog2(WIDTH)-1:0] is the shift amount)
//   func_i, ci_i         operation code, carry/borrow in for ADC/SBC
//   out_valid_o/out_ready_i  result handshake (out_valid_o only in DONE)
//   y_o                  result / product low half / quotient
//   y_hi_o               product high half (MUL), remainder (DIV), else 0
//   co_o, negative_o, zero_o, overflow_o   flags registered with the result
//   busy_o               high while an iterative operation is in progress
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       func_i,
  input  logic             ci_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH-1:0] y_hi_o,
  output logic             co_o,
  output logic             negative_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
    OP_MUL = 4'h4, OP_MLL = 4'h5, OP_DIV = 4'h6, OP_RAS = 4'h7,
    OP_LSH = 4'h8, OP_RSH = 4'h9, OP_LRT = 4'hA, OP_RRT = 4'hB,
    OP_AND = 4'hC, OP_OR  = 4'hD, OP_XOR = 4'hE, OP_NOT = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  op_e op_in;
  assign op_in = op_e'(func_i);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated directly on the incoming operands
  // ---------------------------------------------------------------------------
  logic [SW-1:0]      sh_amt, sh_amt_m1, sh_amt_neg;
  logic               cin;
  logic [WIDTH:0]     add_u, add_s, sub_u, sub_s;
  logic [2*WIDTH-1:0] rot_l, rot_r;
  logic [WIDTH-1:0]   sc_y, sc_y_hi;
  logic               sc_co, sc_ov;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    sc_y       = '0;
    sc_y_hi    = '0;
    sc_co      = 1'b0;
    sc_ov      = 1'b0;
    sh_amt     = b_i[SW-1:0];
    sh_amt_m1  = sh_amt - SW'(1);
    // Modulo 2^SW this equals WIDTH - amount, the index of the last bit
    // leaving a left shift (only used when the amount is non-zero).
    sh_amt_neg = '0 - sh_amt;
    cin        = (op_in == OP_ADC || op_in == OP_SBC) ? ci_i : 1'b0;
    // Unsigned copies give carry/borrow; sign-extended copies give overflow
    // as "true result does not fit in WIDTH bits", which stays correct when
    // the carry-in pushes the result past the limit.
    add_u = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin};
    add_s = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i} + {{WIDTH{1'b0}}, cin};
    sub_u = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin};
    sub_s = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i} - {{WIDTH{1'b0}}, cin};
    rot_l = {a_i, a_i} << sh_amt;
    rot_r = {a_i, a_i} >> sh_amt;

    case (op_in)
      OP_ADD, OP_ADC: begin
        sc_y  = add_u[WIDTH-1:0];
        sc_co = add_u[WIDTH];
        sc_ov = add_s[WIDTH] ^ add_s[WIDTH-1];
      end
      OP_SUB, OP_SBC: begin
        sc_y  = sub_u[WIDTH-1:0];
        sc_co = sub_u[WIDTH];
        sc_ov = sub_s[WIDTH] ^ sub_s[WIDTH-1];
      end
      OP_DIV: begin
        // Only taken as a single-cycle op when the divisor is zero.
        sc_y    = '1;
        sc_y_hi = a_i;
        sc_ov   = 1'b1;
      end
      OP_RAS: begin
        sc_y  = $signed(a_i) >>> sh_amt;
        sc_co = (sh_amt != '0) && a_i[sh_amt_m1];
      end
      OP_LSH: begin
        sc_y  = a_i << sh_amt;
        sc_co = (sh_amt != '0) && a_i[sh_amt_neg];
      end
      OP_RSH: begin
        sc_y  = a_i >> sh_amt;
        sc_co = (sh_amt != '0) && a_i[sh_amt_m1];
      end
      OP_LRT:  sc_y = rot_l[2*WIDTH-1:WIDTH];
      OP_RRT:  sc_y = rot_r[WIDTH-1:0];
      OP_AND:  sc_y = a_i & b_i;
      OP_OR:   sc_y = a_i | b_i;
      OP_XOR:  sc_y = a_i ^ b_i;
      OP_NOT:  sc_y = ~a_i;
      default: ; // MUL/MLL are iterative
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath and control
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  op_e                func_q, func_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // partial product high / remainder
  logic [WIDTH-1:0]   mq_q, mq_d;     // multiplier / dividend -> quotient
  logic [WIDTH-1:0]   dv_q, dv_d;     // multiplicand / divisor
  logic [SW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;   // product sign for the final negate
  logic [WIDTH-1:0]   y_q, y_d, y_hi_q, y_hi_d;
  logic               co_q, co_d, n_q, n_d, z_q, z_d, ov_q, ov_d;

  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [WIDTH+1:0]   trial;
  logic [WIDTH-1:0]   acc_step, mq_step;
  logic [2*WIDTH-1:0] prod;

  // One shift-add (MUL/MLL) or restoring step (DIV) on the current registers.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dv_q} : '0);
    rem_sh  = {acc_q, mq_q[WIDTH-1]};
    trial   = {1'b0, rem_sh} - {2'b00, dv_q};
    if (func_q == OP_DIV) begin
      // A set sign bit on the trial means the divisor did not fit: restore.
      acc_step = trial[WIDTH+1] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
      mq_step  = {mq_q[WIDTH-2:0], ~trial[WIDTH+1]};
    end else begin
      acc_step = mul_sum[WIDTH:1];
      mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
    end
    prod = {acc_step, mq_step};
    if (neg_q) prod = '0 - prod;
  end

  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    co_d    = co_q;
    n_d     = n_q;
    z_d     = z_q;
    ov_d    = ov_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          func_d = op_in;
          if (op_in == OP_MUL || op_in == OP_MLL) begin
            // Multiply magnitudes; the sign is restored at the end.
            acc_d   = '0;
            mq_d    = a_i[WIDTH-1] ? ('0 - a_i) : a_i;
            dv_d    = b_i[WIDTH-1] ? ('0 - b_i) : b_i;
            neg_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            cnt_d   = SW'(WIDTH - 1);
            state_d = S_BUSY;
          end else if (op_in == OP_DIV && b_i != '0) begin
            acc_d   = '0;
            mq_d    = a_i;
            dv_d    = b_i;
            neg_d   = 1'b0;
            cnt_d   = SW'(WIDTH - 1);
            state_d = S_BUSY;
          end else begin
            y_d     = sc_y;
            y_hi_d  = sc_y_hi;
            co_d    = sc_co;
            n_d     = sc_y[WIDTH-1];
            z_d     = (sc_y == '0);
            ov_d    = sc_ov;
            state_d = S_DONE;
          end
        end
      end

      S_BUSY: begin
        acc_d = acc_step;
        mq_d  = mq_step;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          co_d    = 1'b0;
          ov_d    = 1'b0;
          case (func_q)
            OP_MUL: begin
              y_d    = prod[WIDTH-1:0];
              y_hi_d = prod[2*WIDTH-1:WIDTH];
              n_d    = prod[2*WIDTH-1];
              z_d    = (prod == '0);
            end
            OP_MLL: begin
              y_d    = prod[WIDTH-1:0];
              y_hi_d = '0;
              n_d    = prod[WIDTH-1];
              z_d    = (prod[WIDTH-1:0] == '0);
            end
            default: begin // DIV
              y_d    = mq_step;
              y_hi_d = acc_step;
              n_d    = mq_step[WIDTH-1];
              z_d    = (mq_step == '0);
            end
          endcase
        end
      end

      S_DONE: begin
        if (out_ready_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge, regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      func_q  <= OP_ADD;
      acc_q   <= '0;
      mq_q    <= '0;
      dv_q    <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      y_q     <= '0;
      y_hi_q  <= '0;
      co_q    <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      co_q    <= co_d;
      n_q     <= n_d;
      z_q     <= z_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q == S_BUSY);
  assign y_o         = y_q;
  assign y_hi_o      = y_hi_q;
  assign co_o        = co_q;
  assign negative_o  = n_q;
  assign zero_o      = z_q;
  assign overflow_o  = ov_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu - self-checking bench for seq_alu (WIDTH=16 plus one WIDTH=8
// instance). Directed vectors from a table, hand-written handshake / reset
// sequences, and random operations checked against a behavioural model.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] a_s = '0, b_s = '0, y, y_hi;
  logic [3:0]  func_s = '0;
  logic        ci_s = 1'b0, co, negative, zero, overflow, busy;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_s), .b_i(b_s), .func_i(func_s), .ci_i(ci_s),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y), .y_hi_o(y_hi), .co_o(co), .negative_o(negative),
    .zero_o(zero), .overflow_o(overflow), .busy_o(busy)
  );

  // WIDTH=8 instance
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, y8, y_hi8;
  logic [3:0] func8 = '0;
  logic       co8, negative8, zero8, overflow8, busy8;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .a_i(a8), .b_i(b8), .func_i(func8), .ci_i(1'b0),
    .out_valid_o(out_valid8), .out_ready_i(out_ready8),
    .y_o(y8), .y_hi_o(y_hi8), .co_o(co8), .negative_o(negative8),
    .zero_o(zero8), .overflow_o(overflow8), .busy_o(busy8)
  );

  typedef struct {
    logic [15:0] y;
    logic [15:0] yhi;
    logic [3:0]  flg;   // {co, negative, zero, overflow}
    int          lat;   // cycles from accept to out_valid
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic        ci;
    logic [15:0] y;
    logic [15:0] yhi;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the operation rules.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, input logic ci);
    res_t r;
    int ua, ub, sa, sb, c, s, amt;
    longint p;
    logic [31:0] t;
    logic cf, ov, ng, zr;
    ua = int'({16'h0, a});
    ub = int'({16'h0, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    c  = (f == 4'h1 || f == 4'h3) ? int'({31'h0, ci}) : 0;
    amt = ub % 16;
    p  = 0;
    t  = 0;
    cf = 1'b0;
    ov = 1'b0;
    r.yhi = '0;
    r.lat = 1;
    case (f)
      4'h0, 4'h1: begin
        t  = ua + ub + c;
        cf = (ua + ub + c) > 65535;
        s  = sa + sb + c;
        ov = (s > 32767) || (s < -32768);
      end
      4'h2, 4'h3: begin
        t  = ua - ub - c;
        cf = ua < (ub + c);
        s  = sa - sb - c;
        ov = (s > 32767) || (s < -32768);
      end
      4'h4, 4'h5: begin
        p = longint'(sa) * longint'(sb);
        t = p[31:0];
        if (f == 4'h4) r.yhi = p[31:16];
        r.lat = 17;
      end
      4'h6: begin
        if (ub == 0) begin
          t = 32'hFFFF;
          r.yhi = a;
          ov = 1'b1;
        end else begin
          t = ua / ub;
          s = ua % ub;
          r.yhi = s[15:0];
          r.lat = 17;
        end
      end
      4'h7: begin
        t  = sa >>> amt;
        cf = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
      end
      4'h8: begin
        t  = ua << amt;
        cf = (amt != 0) && (((ua >> (16 - amt)) & 1) != 0);
      end
      4'h9: begin
        t  = ua >> amt;
        cf = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0);
      end
      4'hA: t = (ua << amt) | (ua >> (16 - amt));
      4'hB: t = (ua >> amt) | (ua << (16 - amt));
      4'hC: t = ua & ub;
      4'hD: t = ua | ub;
      4'hE: t = ua ^ ub;
      default: t = ~ua;
    endcase
    r.y = t[15:0];
    ng = r.y[15];
    zr = (r.y == 16'h0);
    if (f == 4'h4) begin
      ng = r.yhi[15];
      zr = (p == 0);
    end
    r.flg = {cf, ng, zr, ov};
    return r;
  endfunction

  // Issue one operation, wait for the result, capture it, then consume it.
  // Called and returns #1 after a rising edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                       input logic ci, output res_t r, output int bc);
    int n;
    a_s = a; b_s = b; func_s = f; ci_s = ci;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    r.lat = 1;
    bc = busy ? 1 : 0;
    while (!out_valid && r.lat < 40) begin
      @(posedge clk); #1;
      r.lat++;
      if (busy) bc++;
    end
    r.y   = y;
    r.yhi = y_hi;
    r.flg = {co, negative, zero, overflow};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r, e;
    int   bc, lat;

    // ---- directed vector table: a, b, func, ci -> y, y_hi, {co,n,z,v}, lat
    vecs.push_back('{16'h4000, 16'h4000, 4'h0, 1'b0, 16'h8000, 16'h0000, 4'b0101, 1});
    vecs.push_back('{16'hFFFF, 16'h0001, 4'h0, 1'b0, 16'h0000, 16'h0000, 4'b1010, 1});
    vecs.push_back('{16'hFFF6, 16'h0046, 4'h3, 1'b1, 16'hFFAF, 16'h0000, 4'b0100, 1});
    vecs.push_back('{16'hFFF6, 16'h0046, 4'h1, 1'b1, 16'h003D, 16'h0000, 4'b1000, 1});
    vecs.push_back('{16'h0100, 16'h0100, 4'h4, 1'b0, 16'h0000, 16'h0001, 4'b0000, 17});
    vecs.push_back('{16'h0007, 16'hFFFA, 4'h4, 1'b0, 16'hFFD6, 16'hFFFF, 4'b0100, 17});
    vecs.push_back('{16'h0007, 16'hFFFA, 4'h5, 1'b0, 16'hFFD6, 16'h0000, 4'b0100, 17});
    vecs.push_back('{16'h0064, 16'h0007, 4'h6, 1'b0, 16'h000E, 16'h0002, 4'b0000, 17});
    vecs.push_back('{16'h0005, 16'h0000, 4'h6, 1'b0, 16'hFFFF, 16'h0005, 4'b0101, 1});
    vecs.push_back('{16'hFFF1, 16'h0002, 4'h7, 1'b0, 16'hFFFC, 16'h0000, 4'b0100, 1});
    vecs.push_back('{16'h0025, 16'h0001, 4'h9, 1'b0, 16'h0012, 16'h0000, 4'b1000, 1});
    vecs.push_back('{16'h800A, 16'h0002, 4'hB, 1'b0, 16'hA002, 16'h0000, 4'b0100, 1});
    vecs.push_back('{16'h0002, 16'h000F, 4'h8, 1'b0, 16'h0000, 16'h0000, 4'b1010, 1});
    vecs.push_back('{16'h8000, 16'h0001, 4'h2, 1'b0, 16'h7FFF, 16'h0000, 4'b0001, 1});
    vecs.push_back('{16'h0001, 16'h0002, 4'h2, 1'b0, 16'hFFFF, 16'h0000, 4'b1100, 1});
    vecs.push_back('{16'h0000, 16'h7FFF, 4'h3, 1'b1, 16'h8000, 16'h0000, 4'b1100, 1});
    vecs.push_back('{16'h8001, 16'h0001, 4'hA, 1'b0, 16'h0003, 16'h0000, 4'b0000, 1});
    vecs.push_back('{16'h8000, 16'h0000, 4'h7, 1'b0, 16'h8000, 16'h0000, 4'b0100, 1});
    vecs.push_back('{16'h0000, 16'h0000, 4'hF, 1'b0, 16'hFFFF, 16'h0000, 4'b0100, 1});
    vecs.push_back('{16'h00FF, 16'h0FF0, 4'hE, 1'b0, 16'h0F0F, 16'h0000, 4'b0000, 1});
    vecs.push_back('{16'h0000, 16'h0005, 4'h4, 1'b0, 16'h0000, 16'h0000, 4'b0010, 17});
    vecs.push_back('{16'hFFFF, 16'h0001, 4'h6, 1'b0, 16'hFFFF, 16'h0000, 4'b0100, 17});

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_y_hi", 64'(y_hi), 64'd0);
    check("rst_flags", 64'({co, negative, zero, overflow}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].ci, r, bc);
      check($sformatf("vec%0d_y", i), 64'(r.y), 64'(vecs[i].y));
      check($sformatf("vec%0d_y_hi", i), 64'(r.yhi), 64'(vecs[i].yhi));
      check($sformatf("vec%0d_flags", i), 64'(r.flg), 64'(vecs[i].flg));
      check($sformatf("vec%0d_latency", i), 64'(r.lat), 64'(vecs[i].lat));
      if (vecs[i].lat > 1) check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd16);
    end

    // ---- hold result with out_ready low; in_valid in DONE must be ignored
    a_s = 16'h1234; b_s = 16'h1111; func_s = 4'h0; ci_s = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    a_s = 16'h0001; b_s = 16'h0001;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
      check($sformatf("stall%0d_y", k), 64'({y, co, negative, zero, overflow}),
            64'({16'h2345, 4'b0000}));
      @(posedge clk); #1;
    end
    // Consume with in_valid still high: new op waits for IDLE.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_out_valid", 64'(out_valid), 64'd0);
    check("consume_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next_out_valid", 64'(out_valid), 64'd1);
    check("next_y", 64'(y), 64'h0002);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // ---- reset during MUL BUSY
    a_s = 16'h0100; b_s = 16'h0100; func_s = 4'h4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_y", 64'(y), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h0003, 16'h0004, 4'h0, 1'b0, r, bc);
    check("after_rst_y", 64'(r.y), 64'h0007);
    check("after_rst_latency", 64'(r.lat), 64'd1);

    // ---- WIDTH=8: 16*16 = 256 -> y=0, y_hi=1 after 9 cycles
    a8 = 8'd16; b8 = 8'd16; func8 = 4'h4;
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w8_latency", 64'(lat), 64'd9);
    check("w8_y", 64'(y8), 64'd0);
    check("w8_y_hi", 64'(y_hi8), 64'd1);
    check("w8_flags", 64'({co8, negative8, zero8, overflow8}), 64'd0);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;

    // ---- random operations against the model
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rf;
      logic        rc;
      rf = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom);
      rc = 1'($urandom);
      e = model(ra, rb, rf, rc);
      do_op(ra, rb, rf, rc, r, bc);
      check($sformatf("rnd%0d_f%0h_y", i, rf), 64'(r.y), 64'(e.y));
      check($sformatf("rnd%0d_f%0h_y_hi", i, rf), 64'(r.yhi), 64'(e.yhi));
      check($sformatf("rnd%0d_f%0h_flags", i, rf), 64'(r.flg), 64'(e.flg));
      check($sformatf("rnd%0d_f%0h_latency", i, rf), 64'(r.lat), 64'(e.lat));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 16-bit combinational ALU.
- Adds a valid/ready handshake, generic operand WIDTH, iterative multi-cycle MUL/MLL, and a new unsigned DIV op in the previously unused encoding 0110.
- Sits between the register-file read stage and write-back.
- The high product half (MUL) or the remainder (DIV) is returned on y_hi for write-back to register A.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 4. Shift amount is b[clog2(WIDTH)-1:0].

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands/func valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand A
b  in  WIDTH  operand B / shift amount
func  in  4  operation code
ci  in  1  carry/borrow in (ADC, SBC)
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
y  out  WIDTH  result / product low half / quotient
y_hi  out  WIDTH  product high half (MUL), remainder (DIV), else 0
co  out  1  carry out / borrow / last bit shifted out
negative  out  1  sign flag
zero  out  1  zero flag
overflow  out  1  signed overflow / divide-by-zero
busy  out  1  high in BUSY state

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; y, y_hi, co, negative, zero, overflow all 0. Reset mid-operation aborts the operation; the partial result is discarded.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b, func, ci.
    - Single-cycle ops go to DONE; out_valid=1 on the next cycle (latency 1).
    - MUL, MLL and DIV with b!=0 go to BUSY.
    - DIV with b=0 goes directly to DONE.
  - BUSY: one shift-add / restore step per cycle, WIDTH cycles, then DONE. Total latency = WIDTH+1 cycles from accept. in_ready=0; in_valid is ignored.
  - DONE: out_valid=1; outputs stay stable until out_ready=1, then go to IDLE. in_ready=0 in DONE (no overlap).
- Ops (flags registered with the result):
  - 0000 ADD: y=a+b. co=carry out; overflow=signed overflow.
  - 0001 ADC: y=a+b+ci. co and overflow as ADD.
  - 0010 SUB: y=a-b. co=borrow (1 when a<b unsigned); overflow=signed overflow.
  - 0011 SBC: y=a-b-ci. co and overflow as SUB.
  - 0100 MUL: signed; {y_hi,y}=a*b, computed on magnitudes with final conditional negate. negative=y_hi MSB; zero=full 2*WIDTH product==0; co=overflow=0.
  - 0101 MLL: as MUL, but y_hi=0 and flags are computed on y only.
  - 0110 DIV: unsigned restoring division; y=quotient, y_hi=remainder.
    - b=0: y=all ones, y_hi=a, overflow=1.
  - 0111 RAS: arithmetic right shift. co=last bit shifted out (0 if amount=0).
  - 1000 LSH: logical left shift. co=last bit shifted out (0 if amount=0).
  - 1001 RSH: logical right shift. co=last bit shifted out (0 if amount=0).
  - 1010 LRT: rotate left; co=0.
  - 1011 RRT: rotate right; co=0.
  - 1100 AND, 1101 OR, 1110 XOR: co=0, overflow=0.
  - 1111 NOT: y=~a; co=0, overflow=0.
- Default flags unless stated above: negative=y[WIDTH-1]; zero=(y==0); co and overflow are 0 except where listed.
- y_hi=0 for all ops except MUL and DIV.
- in_valid and out_ready asserted together in DONE: the result is consumed; the new operation is not accepted until IDLE (next cycle).

Test Plan:
- ADD a=16'h4000, b=16'h4000 -> one cycle after accept: y=16'h8000, co=0, negative=1, zero=0, overflow=1. Then a=16'hFFFF, b=1 -> y=0, co=1, zero=1.
- SBC a=-10, b=70, ci=1 -> y=-81, co=0, negative=1. Then ADC with the same operands -> y=61, co=1.
- MUL a=256, b=256 -> out_valid exactly 17 cycles after accept, busy high for 16 cycles, y=0, y_hi=1, zero=0. Then MUL a=7, b=-6 -> y=-42, y_hi=16'hFFFF, negative=1.
- DIV a=100, b=7 -> y=14, y_hi=2 after 17 cycles. DIV a=5, b=0 -> next cycle: y=16'hFFFF, y_hi=5, overflow=1.
- Shifts/rotates:
  - RAS a=-15, b=2 -> y=-4, co=0.
  - RSH a=6'b100101, b=1 -> y=5'b10010, co=1.
  - RRT a=16'h800A, b=2 -> y=16'hA002, negative=1.
  - LSH a=2, b=15 -> y=0, co=1.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles -> y and flags stable, in_ready=0.
  - Assert rst_n=0 during MUL BUSY -> out_valid=0, in_ready=1 immediately.
  - Re-run with WIDTH=8: MUL 16*16 -> y=0, y_hi=1 after 9 cycles.
